// File: rtl/uart_rx_fsm.sv
// Control FSM for a UART receiver. It sequences the start, data, parity and stop
// bits using an external edge/bit counter, and pulses data_valid after each good frame.
module uart_rx_fsm #(
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           RX_IN,
    input  logic                           PAR_EN,
    input  logic [5:0]                     Prescale,
    input  logic [$clog2(IN_DATA_WIDTH):0] bit_cnt,
    input  logic [5:0]                     edge_cnt,
    input  logic                           strt_glitch,
    input  logic                           par_err,
    input  logic                           stp_err,
    output logic                           edge_bit_en,
    output logic                           dat_samp_en,
    output logic                           deser_en,
    output logic                           strt_chk_en,
    output logic                           par_chk_en,
    output logic                           stp_chk_en,
    output logic                           data_valid,
    output logic [2:0]                     fsm_state
);

    localparam int BCW = $clog2(IN_DATA_WIDTH) + 1;
    localparam logic [BCW-1:0] LAST_DATA_BIT = BCW'(IN_DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;
    logic   bit_end;
    logic   frame_start;
    logic   par_en_lat;
    logic   par_flag;

    assign bit_end     = (edge_cnt == (Prescale - 6'd1));
    assign frame_start = (state == IDLE) && !RX_IN;
    assign fsm_state   = state;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = RX_IN ? IDLE : START;
            // A high RX_IN during the start bit is deliberately ignored; only strt_glitch decides.
            START:   next_state = !bit_end ? START : (strt_glitch ? IDLE : DATA);
            DATA: begin
                if (bit_end && (bit_cnt == LAST_DATA_BIT)) begin
                    next_state = par_en_lat ? PARITY : STOP;
                end else begin
                    next_state = DATA;
                end
            end
            PARITY:  next_state = bit_end ? STOP : PARITY;
            STOP:    next_state = bit_end ? IDLE : STOP;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        edge_bit_en = 1'b0;
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        case (state)
            START: begin
                edge_bit_en = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = bit_end;
            end
            DATA: begin
                edge_bit_en = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = bit_end;
            end
            PARITY: begin
                edge_bit_en = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = bit_end;
            end
            STOP: begin
                edge_bit_en = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = bit_end;
            end
            default: ;
        endcase
    end

    // Frame-scoped flags: parity mode is frozen for the frame, the parity error survives to the stop bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            par_en_lat <= 1'b0;
            par_flag   <= 1'b0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= (state == STOP) && bit_end && !stp_err && !par_flag;
            if (frame_start) begin
                par_en_lat <= PAR_EN;
                par_flag   <= 1'b0;
            end else if ((state == PARITY) && bit_end) begin
                par_flag <= par_err;
            end
        end
    end

endmodule
